// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side controller for a synchronous FIFO with one cycle of read latency.
// It pops words from the FIFO and presents them downstream on a valid/ready
// stream through a two-entry output buffer. It never reads an empty FIFO and
// it counts the words it captures. A FIFO underflow is latched as a sticky
// error.
//
// Ports
//   clk              : clock; all state updates on the rising edge
//   rst_n            : asynchronous active-low reset
//   drain_en         : level; 1 = controller may pop the FIFO
//   fifo_empty       : FIFO empty flag
//   fifo_almostempty : FIFO almost-empty flag (only one word left)
//   fifo_underflow   : FIFO underflow flag (registered inside the FIFO)
//   fifo_data_out    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       : FIFO read strobe (combinational)
//   m_data           : head word of the output buffer
//   m_valid          : output buffer is non-empty
//   m_ready          : downstream accepts m_data this cycle
//   busy             : a read is in flight or the buffer is non-empty
//   rd_count         : words captured since reset (wraps)
//   underflow_err    : sticky FIFO underflow indication
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_occ;        // buffer occupancy, 0..2
    logic                  r_inflight;   // a FIFO read was issued last cycle
    logic [FIFO_WIDTH-1:0] r_buf_head;   // entry presented on m_data
    logic [FIFO_WIDTH-1:0] r_buf_tail;   // second entry, valid when r_occ == 2
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic                  r_underflow_err;

    logic                  w_pop;
    logic [1:0]            w_level;
    logic                  w_rd_en;
    logic                  w_unused_almostempty;

    // The read equation already keeps reads ordered against the last word in
    // the FIFO, so the almost-empty flag carries no extra information here.
    assign w_unused_almostempty = fifo_almostempty;

    assign w_pop   = m_valid && m_ready;

    // Words already committed to the buffer: stored plus the one in flight.
    // Occupancy never exceeds 2 and inflight is 1 bit, so 2 bits suffice.
    assign w_level = r_occ + {1'b0, r_inflight};

    // A new read is allowed when the committed level leaves room, or when the
    // buffer is exactly committed-full but a word leaves this cycle. This is
    // what gives one word per clock with m_ready held high and keeps the
    // buffer from ever overflowing.
    assign w_rd_en = rst_n
                  && (r_state == ST_RUN)
                  && !fifo_empty
                  && ((w_level < 2'd2) || ((w_level == 2'd2) && w_pop));

    assign fifo_rd_en    = w_rd_en;
    assign m_data        = r_buf_head;
    assign m_valid       = (r_occ != 2'd0);
    assign busy          = r_inflight || (r_occ != 2'd0);
    assign rd_count      = r_rd_count;
    assign underflow_err = r_underflow_err;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers sample the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (drain_en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A read issued on the final RUN cycle is still captured
                    // by the datapath; STOP only covers the word already in
                    // flight when drain_en drops.
                    if (!drain_en) begin
                        r_state <= r_inflight ? ST_STOP : ST_IDLE;
                    end
                end
                ST_STOP: begin
                    // The in-flight word is captured on this edge, so leaving
                    // now (even back to RUN) never precedes the capture.
                    r_state <= drain_en ? ST_RUN : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: in-flight tracking, two-entry buffer, counters
    // -----------------------------------------------------------------------
    // NOTE: the buffer entries are reset because m_data must read 0 out of
    // reset; with only two entries this is a plain register pair, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_occ           <= 2'd0;
            r_buf_head      <= '0;
            r_buf_tail      <= '0;
            r_rd_count      <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;

            if (r_inflight) begin
                r_rd_count <= r_rd_count + 1'b1;
            end

            if (fifo_underflow) begin
                r_underflow_err <= 1'b1;
            end

            case ({r_inflight, w_pop})
                2'b10: begin
                    // Capture only: append behind whatever is stored.
                    if (r_occ == 2'd0) begin
                        r_buf_head <= fifo_data_out;
                        r_occ      <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_buf_tail <= fifo_data_out;
                        r_occ      <= 2'd2;
                    end
                end
                2'b01: begin
                    // Pop only: the tail (if any) moves up to the head.
                    r_buf_head <= r_buf_tail;
                    r_occ      <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy is unchanged.
                    if (r_occ == 2'd1) begin
                        r_buf_head <= fifo_data_out;
                    end else begin
                        r_buf_head <= r_buf_tail;
                        r_buf_tail <= fifo_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_read_ctrl. A small behavioural FIFO (one cycle read
// latency) feeds the controller; every word written to it is queued as the
// expected stream and compared when the controller hands it downstream. A
// second instance with a 3-bit counter shares all inputs so counter
// wrap-around is seen within a short run.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          drain_en;
    logic          fifo_empty;
    logic          fifo_almostempty;
    logic          fifo_underflow;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic [15:0]   rd_count;
    logic          underflow_err;

    // Outputs of the narrow-counter instance.
    logic          s_fifo_rd_en;
    logic [W-1:0]  s_m_data;
    logic          s_m_valid;
    logic          s_busy;
    logic [2:0]    s_rd_count;
    logic          s_underflow_err;

    always #5 clk = ~clk;

    fifo_read_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .drain_en         (drain_en),
        .fifo_empty       (fifo_empty),
        .fifo_almostempty (fifo_almostempty),
        .fifo_underflow   (fifo_underflow),
        .fifo_data_out    (fifo_data_out),
        .fifo_rd_en       (fifo_rd_en),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .busy             (busy),
        .rd_count         (rd_count),
        .underflow_err    (underflow_err)
    );

    fifo_read_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(3)) u_dut_w3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .drain_en         (drain_en),
        .fifo_empty       (fifo_empty),
        .fifo_almostempty (fifo_almostempty),
        .fifo_underflow   (fifo_underflow),
        .fifo_data_out    (fifo_data_out),
        .fifo_rd_en       (s_fifo_rd_en),
        .m_data           (s_m_data),
        .m_valid          (s_m_valid),
        .m_ready          (m_ready),
        .busy             (s_busy),
        .rd_count         (s_rd_count),
        .underflow_err    (s_underflow_err)
    );

    // ---------------- behavioural FIFO ----------------
    logic [W-1:0] fifo_mem [0:63];
    int           wr_ptr = 0;
    int           rd_ptr = 0;

    assign fifo_empty       = (wr_ptr == rd_ptr);
    assign fifo_almostempty = ((wr_ptr - rd_ptr) == 1);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= fifo_mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // ---------------- scoreboard and statistics ----------------
    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    int n_rd, first_rd, last_rd;
    int n_pop, first_pop, last_pop;
    int bad_rd = 0;
    int wcyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    task automatic clear_stats();
        n_rd = 0; first_rd = -1; last_rd = -1;
        n_pop = 0; first_pop = -1; last_pop = -1;
    endtask

    // One clock: observe at the falling edge, then return just after the
    // next rising edge where the caller drives new inputs.
    task automatic tick();
        logic [W-1:0] exp;
        @(negedge clk);
        ncyc++;
        if (fifo_rd_en) begin
            if (fifo_empty) bad_rd++;
            if (n_rd == 0) first_rd = ncyc;
            last_rd = ncyc;
            n_rd++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_pop_expected", exp_q.size(), 1);
            end else begin
                exp = exp_q.pop_front();
                check("sb_data", m_data, exp);
            end
            if (n_pop == 0) first_pop = ncyc;
            last_pop = ncyc;
            n_pop++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        drain_en       = 1'b0;
        fifo_underflow = 1'b0;
        m_ready        = 1'b0;
        clear_stats();

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_underflow_err", underflow_err, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- full-throughput drain of 8 words ----------------
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        drain_en = 1'b1;
        m_ready  = 1'b1;
        clear_stats();
        repeat (14) tick();
        check("t1_rd_cycles", n_rd, 8);
        check("t1_rd_contiguous", last_rd - first_rd, 7);
        check("t1_first_data_lat", first_pop - first_rd, 2);
        check("t1_pops", n_pop, 8);
        check("t1_pop_contiguous", last_pop - first_pop, 7);
        check("t1_rd_count", rd_count, 8);
        check("t1_rd_count_wrap3", s_rd_count, 0);
        check("t1_rd_en_low_empty", fifo_rd_en, 0);

        // ---------------- back-pressure: buffer fills to two ----------------
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(W'(16'h0100 + i));
        clear_stats();
        repeat (8) tick();
        check("t2_rd_cycles", n_rd, 2);
        check("t2_m_valid", m_valid, 1);
        check("t2_m_data", m_data, 16'h0101);
        check("t2_busy", busy, 1);
        check("t2_fifo_level", wr_ptr - rd_ptr, 2);
        repeat (3) tick();
        check("t2_m_data_hold", m_data, 16'h0101);
        check("t2_no_pop", n_pop, 0);
        m_ready = 1'b1;
        clear_stats();
        repeat (8) tick();
        check("t2_pops", n_pop, 4);
        check("t2_pop_contiguous", last_pop - first_pop, 3);
        check("t2_rd_count", rd_count, 12);
        check("t2_rd_count_w3", s_rd_count, 4);
        check("t2_drained", m_valid, 0);

        // ---------------- empty FIFO, then a single late word ----------------
        clear_stats();
        repeat (20) tick();
        check("t3_no_rd", n_rd, 0);
        check("t3_m_valid", m_valid, 0);
        check("t3_underflow_err", underflow_err, 0);
        push_word(16'hA5A5);
        wcyc = ncyc + 1;
        clear_stats();
        repeat (5) tick();
        check("t3_valid_latency", first_pop - wcyc, 2);
        check("t3_pops", n_pop, 1);
        check("t3_rd_count", rd_count, 13);

        // ---------------- drain_en drops on a read cycle ----------------
        for (int i = 1; i <= 6; i++) push_word(W'(16'h0200 + i));
        repeat (2) tick();
        drain_en = 1'b0;
        clear_stats();
        tick();
        check("t4_state_stop", u_dut.r_state, 2);
        check("t4_rd_count_a", rd_count, 15);
        tick();
        check("t4_state_idle", u_dut.r_state, 0);
        check("t4_rd_count_b", rd_count, 16);
        repeat (4) tick();
        check("t4_rd_cycles", n_rd, 1);
        check("t4_rd_count_final", rd_count, 16);
        check("t4_pops", n_pop, 3);
        check("t4_busy", busy, 0);
        check("t4_fifo_level", wr_ptr - rd_ptr, 3);

        // ---------------- reset with a word in flight and one buffered ----------------
        drain_en = 1'b1;
        m_ready  = 1'b0;
        repeat (3) tick();
        check("t5_pre_inflight", busy, 1);
        check("t5_pre_m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_m_valid", m_valid, 0);
        check("t5_rst_rd_count", rd_count, 0);
        check("t5_rst_rd_count_w3", s_rd_count, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", fifo_rd_en, 0);
        // The buffered word and the in-flight word are discarded.
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        repeat (2) tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        check("t5_no_capture_after_release", rd_count, 0);
        check("t5_no_valid_after_release", m_valid, 0);
        clear_stats();
        repeat (6) tick();
        check("t5_pops", n_pop, 1);
        check("t5_rd_count", rd_count, 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // ---------------- sticky underflow ----------------
        check("t6_err_before", underflow_err, 0);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        check("t6_err_set", underflow_err, 1);
        repeat (5) tick();
        check("t6_err_sticky", underflow_err, 1);
        rst_n = 1'b0;
        #1;
        check("t6_err_cleared", underflow_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        check("never_rd_when_empty", bad_rd, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
